// File: rtl/execute_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : execute_stage                                                   |
// | Brief    : Pipeline EX stage. Operand select, integer ALU and the EX/MEM   |
// |            register. Defining EXEC_MULDIV_EN adds RV32M multiply and an    |
// |            iterative restoring divider that back-pressures decode.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module execute_stage #(
  parameter int unsigned CTRL_W    = 16,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       dec_instr_i,
  input  logic [CTRL_W-1:0] dec_control_i,
  input  logic [31:0]       dec_rs1_data_i,
  input  logic [31:0]       dec_rs2_data_i,
  input  logic [31:0]       dec_imm_i,
  input  logic              dec_alu_src_i,
  input  logic [4:0]        dec_alu_op_i,
  input  logic [4:0]        dec_rd_addr_i,
  input  logic [31:0]       dec_pcplus_i,
  output logic              dec_ready_o,
  output logic [31:0]       mem_instr_o,
  output logic [CTRL_W-1:0] mem_control_o,
  output logic [31:0]       mem_aluResult_o,
  output logic [31:0]       mem_data_o,
  output logic [4:0]        mem_rd_addr_o,
  output logic [31:0]       mem_pcplus_o,
  input  logic              mem_ready_i
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
`ifdef EXEC_MULDIV_EN
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;
`endif

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] base_result;
  logic [31:0] ex_result;
  logic        dec_ready;
  logic        load_payload;
  logic        load_bubble;

  logic [31:0]       instr_q, instr_d;
  logic [CTRL_W-1:0] control_q, control_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       data_q, data_d;
  logic [4:0]        rd_addr_q, rd_addr_d;
  logic [31:0]       pcplus_q, pcplus_d;

  assign op_a = dec_rs1_data_i;
  assign op_b = dec_alu_src_i ? dec_imm_i : dec_rs2_data_i;

  always_comb begin
    base_result = '0;
    case (dec_alu_op_i)
      OP_ADD:   base_result = op_a + op_b;
      OP_SUB:   base_result = op_a - op_b;
      OP_SLL:   base_result = op_a << op_b[4:0];
      OP_SLT:   base_result = {31'd0, ($signed(op_a) < $signed(op_b))};
      OP_SLTU:  base_result = {31'd0, (op_a < op_b)};
      OP_XOR:   base_result = op_a ^ op_b;
      OP_SRL:   base_result = op_a >> op_b[4:0];
      OP_SRA:   base_result = $signed(op_a) >>> op_b[4:0];
      OP_OR:    base_result = op_a | op_b;
      OP_AND:   base_result = op_a & op_b;
      OP_PASSB: base_result = op_b;
      default:  base_result = '0;
    endcase
  end

`ifdef EXEC_MULDIV_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] part_rem_q, part_rem_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic        rem_sel_q, rem_sel_d;

  logic [63:0] prod_u;
  logic [31:0] corr_a, corr_b;
  logic [31:0] mulhu, mulhsu, mulh;
  logic        is_div, div_signed, div_rem, div_zero, div_ovf, div_fast;
  logic [31:0] fast_result, mag_a, mag_b, div_final, alu_result;
  logic [32:0] shifted, trial;

  // One unsigned multiplier; signed high words are recovered by subtracting
  // the cross terms that two's-complement operands contribute.
  assign prod_u = {32'd0, op_a} * {32'd0, op_b};
  assign corr_a = op_a[31] ? op_b : 32'd0;
  assign corr_b = op_b[31] ? op_a : 32'd0;
  assign mulhu  = prod_u[63:32];
  assign mulhsu = mulhu - corr_a;
  assign mulh   = mulhu - corr_a - corr_b;

  assign is_div     = dec_alu_op_i inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign div_signed = (dec_alu_op_i == OP_DIV) || (dec_alu_op_i == OP_REM);
  assign div_rem    = (dec_alu_op_i == OP_REM) || (dec_alu_op_i == OP_REMU);
  assign div_zero   = (op_b == 32'd0);
  assign div_ovf    = div_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign div_fast   = div_zero || div_ovf;
  assign mag_a      = (div_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
  assign mag_b      = (div_signed && op_b[31]) ? (32'd0 - op_b) : op_b;

  always_comb begin
    fast_result = '0;
    if (div_zero) begin
      fast_result = div_rem ? op_a : 32'hFFFF_FFFF;
    end else begin
      fast_result = div_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  always_comb begin
    alu_result = base_result;
    case (dec_alu_op_i)
      OP_MUL:    alu_result = prod_u[31:0];
      OP_MULH:   alu_result = mulh;
      OP_MULHSU: alu_result = mulhsu;
      OP_MULHU:  alu_result = mulhu;
      OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_result = fast_result;
      default:   alu_result = base_result;
    endcase
  end

  // Restoring step: trial[32] set means the shifted remainder is below the divisor.
  assign shifted   = {part_rem_q, quot_q[31]};
  assign trial     = shifted - {1'b0, divisor_q};
  assign div_final = rem_sel_q ? (neg_rem_q  ? (32'd0 - part_rem_q) : part_rem_q)
                               : (neg_quot_q ? (32'd0 - quot_q)     : quot_q);
  assign ex_result = (state_q == S_DONE) ? div_final : alu_result;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quot_d       = quot_q;
    part_rem_d   = part_rem_q;
    divisor_d    = divisor_q;
    neg_quot_d   = neg_quot_q;
    neg_rem_d    = neg_rem_q;
    rem_sel_d    = rem_sel_q;
    dec_ready    = mem_ready_i;
    load_payload = 1'b0;
    load_bubble  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_div && !div_fast) begin
          dec_ready  = 1'b0;
          quot_d     = mag_a;
          part_rem_d = '0;
          divisor_d  = mag_b;
          neg_quot_d = div_signed && (op_a[31] ^ op_b[31]);
          neg_rem_d  = div_signed && op_a[31];
          rem_sel_d  = div_rem;
          cnt_d      = '0;
          state_d    = S_BUSY;
        end else begin
          load_payload = mem_ready_i;
        end
      end
      S_BUSY: begin
        dec_ready   = 1'b0;
        load_bubble = mem_ready_i;
        if (trial[32]) begin
          part_rem_d = shifted[31:0];
          quot_d     = {quot_q[30:0], 1'b0};
        end else begin
          part_rem_d = trial[31:0];
          quot_d     = {quot_q[30:0], 1'b1};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        load_payload = mem_ready_i;
        if (mem_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      quot_q     <= '0;
      part_rem_q <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      rem_sel_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      quot_q     <= quot_d;
      part_rem_q <= part_rem_d;
      divisor_q  <= divisor_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      rem_sel_q  <= rem_sel_d;
    end
  end
`else
  assign dec_ready    = mem_ready_i;
  assign load_payload = mem_ready_i;
  assign load_bubble  = 1'b0;
  assign ex_result    = base_result;
`endif

  assign dec_ready_o = dec_ready;

  always_comb begin
    instr_d   = instr_q;
    control_d = control_q;
    result_d  = result_q;
    data_d    = data_q;
    rd_addr_d = rd_addr_q;
    pcplus_d  = pcplus_q;
    if (load_payload) begin
      instr_d   = dec_instr_i;
      control_d = dec_control_i;
      result_d  = ex_result;
      data_d    = dec_rs2_data_i;
      rd_addr_d = dec_rd_addr_i;
      pcplus_d  = dec_pcplus_i;
    end else if (load_bubble) begin
      instr_d   = NOP_INSTR;
      control_d = '0;
      result_d  = '0;
      data_d    = '0;
      rd_addr_d = '0;
      pcplus_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q   <= NOP_INSTR;
      control_q <= '0;
      result_q  <= '0;
      data_q    <= '0;
      rd_addr_q <= '0;
      pcplus_q  <= '0;
    end else begin
      instr_q   <= instr_d;
      control_q <= control_d;
      result_q  <= result_d;
      data_q    <= data_d;
      rd_addr_q <= rd_addr_d;
      pcplus_q  <= pcplus_d;
    end
  end

  assign mem_instr_o     = instr_q;
  assign mem_control_o   = control_q;
  assign mem_aluResult_o = result_q;
  assign mem_data_o      = data_q;
  assign mem_rd_addr_o   = rd_addr_q;
  assign mem_pcplus_o    = pcplus_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_execute_stage                                                |
// | Brief    : Scoreboard bench for execute_stage; expectations follow          |
// |            EXEC_MULDIV_EN when it is defined.                              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_execute_stage;
  localparam int unsigned CTRL_W = 16;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef EXEC_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif
  localparam int SLOW = MD ? 33 : 0;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_PASSB = 5'd10;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22,   OP_REMU = 5'd23;

  logic              clk = 1'b0;
  logic              rst_i;
  logic [31:0]       dec_instr_i;
  logic [CTRL_W-1:0] dec_control_i;
  logic [31:0]       dec_rs1_data_i, dec_rs2_data_i, dec_imm_i, dec_pcplus_i;
  logic              dec_alu_src_i;
  logic [4:0]        dec_alu_op_i, dec_rd_addr_i;
  logic              dec_ready_o;
  logic [31:0]       mem_instr_o, mem_aluResult_o, mem_data_o, mem_pcplus_o;
  logic [CTRL_W-1:0] mem_control_o;
  logic [4:0]        mem_rd_addr_o;
  logic              mem_ready_i;

  typedef struct packed {
    logic [31:0]       instr;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       res;
    logic [31:0]       data;
    logic [4:0]        rd;
    logic [31:0]       pc;
  } pkt_t;

  pkt_t  exp_q[$];
  string name_q[$];
  pkt_t  mon_exp, mon_act;
  string mon_name;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    txn      = 0;
  bit    fire     = 1'b0;

  always #5 clk = ~clk;

  execute_stage #(.CTRL_W(CTRL_W), .NOP_INSTR(NOP)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .dec_instr_i     (dec_instr_i),
    .dec_control_i   (dec_control_i),
    .dec_rs1_data_i  (dec_rs1_data_i),
    .dec_rs2_data_i  (dec_rs2_data_i),
    .dec_imm_i       (dec_imm_i),
    .dec_alu_src_i   (dec_alu_src_i),
    .dec_alu_op_i    (dec_alu_op_i),
    .dec_rd_addr_i   (dec_rd_addr_i),
    .dec_pcplus_i    (dec_pcplus_i),
    .dec_ready_o     (dec_ready_o),
    .mem_instr_o     (mem_instr_o),
    .mem_control_o   (mem_control_o),
    .mem_aluResult_o (mem_aluResult_o),
    .mem_data_o      (mem_data_o),
    .mem_rd_addr_o   (mem_rd_addr_o),
    .mem_pcplus_o    (mem_pcplus_o),
    .mem_ready_i     (mem_ready_i)
  );

  // A payload is committed on the edge following a cycle with both handshakes high.
  always @(negedge clk) fire = dec_ready_o && mem_ready_i && !rst_i;

  always @(posedge clk) begin
    #1;
    if (fire) begin
      n_checks++;
      mon_act = {mem_instr_o, mem_control_o, mem_aluResult_o, mem_data_o, mem_rd_addr_o, mem_pcplus_o};
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL payload_unexpected: got instr=%h result=%h, expected no payload", mem_instr_o, mem_aluResult_o);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        if (mon_act !== mon_exp) begin
          n_fail++;
          $display("FAIL %s: got instr=%h ctrl=%h res=%h data=%h rd=%0d pc=%h, expected instr=%h ctrl=%h res=%h data=%h rd=%0d pc=%h",
                   mon_name, mon_act.instr, mon_act.ctrl, mon_act.res, mon_act.data, mon_act.rd, mon_act.pc,
                   mon_exp.instr, mon_exp.ctrl, mon_exp.res, mon_exp.data, mon_exp.rd, mon_exp.pc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic src);
    dec_instr_i    = 32'h00A0_0000 | (32'(txn) << 8) | {27'd0, op};
    dec_control_i  = 16'hC000 ^ 16'(txn);
    dec_rd_addr_i  = 5'(txn) | 5'd1;
    dec_pcplus_i   = 32'h0000_1000 + 32'(txn) * 4;
    dec_rs1_data_i = a;
    dec_rs2_data_i = rs2;
    dec_imm_i      = imm;
    dec_alu_src_i  = src;
    dec_alu_op_i   = op;
  endtask

  task automatic push_exp(input string name, input logic [31:0] res);
    exp_q.push_back({dec_instr_i, dec_control_i, res, dec_rs2_data_i, dec_rd_addr_i, dec_pcplus_i});
    name_q.push_back(name);
  endtask

  task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic src,
                       input logic [31:0] res, input int stall_exp);
    int stalls;
    int nops;
    bit done;
    txn++;
    drive(op, a, rs2, imm, src);
    mem_ready_i = 1'b1;
    push_exp(name, res);
    stalls = 0;
    nops   = 0;
    done   = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c > 0 && mem_instr_o == NOP) nops++;
      if (dec_ready_o && mem_ready_i) begin
        done = 1'b1;
        break;
      end
      stalls++;
    end
    if (done) @(posedge clk);
    #2;
    check({name, "_accepted"}, 32'(done), 32'd1);
    check({name, "_stall_cycles"}, stalls, stall_exp);
    if (stall_exp > 0) check({name, "_bubbles"}, nops, 32'd32);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_instr"}, mem_instr_o, NOP);
    check({name, "_result"}, mem_aluResult_o, 32'd0);
    check({name, "_data"}, mem_data_o, 32'd0);
    check({name, "_pcplus"}, mem_pcplus_o, 32'd0);
    check({name, "_rd_ctrl"}, {11'd0, mem_rd_addr_o, mem_control_o}, 32'd0);
  endtask

  // Divide presented while the memory stage is stalled through BUSY and five DONE cycles.
  task automatic hold_test();
    pkt_t snap;
    int   bad;
    int   nready;
    txn++;
    drive(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'd0, 1'b0);
    mem_ready_i = 1'b0;
    push_exp("div_backpressure", MD ? 32'hFFFF_FFF2 : 32'd0);
    snap   = {mem_instr_o, mem_control_o, mem_aluResult_o, mem_data_o, mem_rd_addr_o, mem_pcplus_o};
    bad    = 0;
    nready = 0;
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      if ({mem_instr_o, mem_control_o, mem_aluResult_o, mem_data_o, mem_rd_addr_o, mem_pcplus_o} !== snap) bad++;
      if (dec_ready_o) nready++;
    end
    check("hold_payload_changes", bad, 32'd0);
    check("hold_ready_cycles", nready, 32'd0);
    @(posedge clk);
    #2;
    mem_ready_i = 1'b1;
    @(negedge clk);
    check("hold_release_ready", {31'd0, dec_ready_o}, 32'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_i       = 1'b1;
    mem_ready_i = 1'b0;
    drive(OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check_reset_state("reset");
    rst_i = 1'b0;

    issue("add_wrap",  OP_ADD,   32'hFFFF_FFFF, 32'h0000_0055, 32'd1,          1'b1, 32'h0000_0000, 0);
    issue("sub",       OP_SUB,   32'd5,         32'd7,         32'd0,          1'b0, 32'hFFFF_FFFE, 0);
    issue("sll_b40",   OP_SLL,   32'd1,         32'h0000_0021, 32'd0,          1'b0, 32'h0000_0002, 0);
    issue("slt",       OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd0,          1'b0, 32'h0000_0001, 0);
    issue("sltu",      OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,          1'b0, 32'h0000_0000, 0);
    issue("xor",       OP_XOR,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0,          1'b0, 32'hFF00_FF00, 0);
    issue("srl",       OP_SRL,   32'h8000_0000, 32'd4,         32'd0,          1'b0, 32'h0800_0000, 0);
    issue("sra_imm",   OP_SRA,   32'h8000_0000, 32'h0000_FFFF, 32'd4,          1'b1, 32'hF800_0000, 0);
    issue("or",        OP_OR,    32'h1234_0000, 32'h0000_5678, 32'd0,          1'b0, 32'h1234_5678, 0);
    issue("and",       OP_AND,   32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0,          1'b0, 32'h0F00_0F00, 0);
    issue("passb",     OP_PASSB, 32'd1,         32'd2,         32'hDEAD_BEEF,  1'b1, 32'hDEAD_BEEF, 0);
    issue("bad_op11",  5'd11,    32'd3,         32'd4,         32'd0,          1'b0, 32'h0000_0000, 0);
    issue("bad_op31",  5'd31,    32'd3,         32'd4,         32'd0,          1'b0, 32'h0000_0000, 0);
    issue("mul",       OP_MUL,   32'd7,         32'hFFFF_FFFD, 32'd0,          1'b0, MD ? 32'hFFFF_FFEB : 32'd0, 0);
    issue("mulh",      OP_MULH,  32'hFFFF_FFFF, 32'd2,         32'd0,          1'b0, MD ? 32'hFFFF_FFFF : 32'd0, 0);
    issue("mulhsu",    OP_MULHSU,32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          1'b0, MD ? 32'hFFFF_FFFF : 32'd0, 0);
    issue("mulhu",     OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,          1'b0, MD ? 32'hFFFF_FFFE : 32'd0, 0);
    issue("divu_by0",  OP_DIVU,  32'd5,         32'd0,         32'd0,          1'b0, MD ? 32'hFFFF_FFFF : 32'd0, 0);
    issue("remu_by0",  OP_REMU,  32'd5,         32'd0,         32'd0,          1'b0, MD ? 32'h0000_0005 : 32'd0, 0);
    issue("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1'b0, MD ? 32'h8000_0000 : 32'd0, 0);
    issue("rem_ovf",   OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,          1'b0, 32'h0000_0000, 0);
    issue("div_m7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'd0,          1'b0, MD ? 32'hFFFF_FFFD : 32'd0, SLOW);
    issue("rem_m7_2",  OP_REM,   32'hFFFF_FFF9, 32'd2,         32'd0,          1'b0, MD ? 32'hFFFF_FFFF : 32'd0, SLOW);
    issue("divu_100_7",OP_DIVU,  32'd100,       32'd7,         32'd0,          1'b0, MD ? 32'h0000_000E : 32'd0, SLOW);
    issue("remu_100_7",OP_REMU,  32'd100,       32'd7,         32'd0,          1'b0, MD ? 32'h0000_0002 : 32'd0, SLOW);
    issue("div_7_m2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd0,          1'b0, MD ? 32'hFFFF_FFFD : 32'd0, SLOW);
    issue("rem_7_m2",  OP_REM,   32'd7,         32'hFFFF_FFFE, 32'd0,          1'b0, MD ? 32'h0000_0001 : 32'd0, SLOW);
    issue("add_after", OP_ADD,   32'd10,        32'd20,        32'd0,          1'b0, 32'd30, 0);

    hold_test();
    issue("add_after_hold", OP_SUB, 32'd1, 32'd1, 32'd0, 1'b0, 32'd0, 0);

    // Divide aborted by reset eleven cycles after it is presented (counter at 10).
    txn++;
    drive(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, 1'b0);
    mem_ready_i = 1'b0;
    repeat (11) @(posedge clk);
    #2;
    rst_i = 1'b1;
    drive(OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0);
    @(posedge clk);
    #2;
    rst_i = 1'b0;
    check_reset_state("mid_div_reset");
    issue("add_post_reset", OP_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 32'd7, 0);

    mem_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
